mod_sched: RTL

- Scheduler that shares one iterative repeated-subtraction MOD engine between NREQ requesters.
- Performs round-robin arbitration and latches the winner's operands.
- Sequences the engine through load / subtract / read using the engine's less-than flag.
- Returns the remainder, or an error for divide-by-zero or iteration timeout, to the granted requester.
- Sits between the ALU-side requesters and the MOD datapath; it replaces per-requester ad-hoc control.

---
 rtl/mod_pkg.sv | 26 ++
 rtl/mod_sched_if.sv | 36 +++
 rtl/mod_rr_arb.sv | 36 +++
 rtl/mod_sched.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// Shared definitions for the MOD scheduler: state encoding, default widths
// and the index-width helper used by the scheduler and its arbiter.
package mod_pkg;

    localparam int DEF_W     = 32;
    localparam int DEF_CNT_W = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SUB  = 3'd2;
    localparam logic [2:0] ST_READ = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        SUB  = ST_SUB,
        READ = ST_READ,
        RESP = ST_RESP
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod_sched_if.sv
// Requester and engine signals of the MOD scheduler.
// master = the scheduler, slave = requesters plus the MOD engine.
interface mod_sched_if
    import mod_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = DEF_W
);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic              done;
    logic [W-1:0]      result;
    logic              err;

    logic              eng_load;
    logic              eng_sub;
    logic              eng_rd;
    logic [W-1:0]      eng_a;
    logic [W-1:0]      eng_b;
    logic              eng_lt;
    logic [W-1:0]      eng_result;

    modport master (
        input  req, a_in, b_in, eng_lt, eng_result,
        output gnt, done, result, err, eng_load, eng_sub, eng_rd, eng_a, eng_b
    );

    modport slave (
        output req, a_in, b_in, eng_lt, eng_result,
        input  gnt, done, result, err, eng_load, eng_sub, eng_rd, eng_a, eng_b
    );

endinterface

// File: rtl/mod_rr_arb.sv
// Combinational round-robin picker: the first set req bit at or after ptr
// (wrapping) wins; grant is one-hot, idx is its position.
module mod_rr_arb
    import mod_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // NOTE: every variable gets a default before the loop, so no latch is inferred.
    always_comb begin
        int   slot;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        slot  = 0;
        for (int i = 0; i < NREQ; i++) begin
            slot = (int'(ptr) + i) % NREQ;
            if (!found && req[slot]) begin
                found       = 1'b1;
                grant[slot] = 1'b1;
                idx         = IDX_W'(slot);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mod_sched.sv
// Shares one repeated-subtraction MOD engine between NREQ requesters:
// round-robin accept, operand latch, load/subtract/read sequencing, response.
module mod_sched
    import mod_pkg::*;
#(
    parameter int             NREQ     = 2,
    parameter int             W        = DEF_W,
    parameter int             CNT_W    = DEF_CNT_W,
    parameter logic [CNT_W-1:0] MAX_ITER = CNT_W'(16'hFFFF)
) (
    input logic        CLK,
    input logic        reset,
    mod_sched_if.master bus
);

    localparam int               IDX_W = idx_width(NREQ);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NREQ - 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    logic [CNT_W-1:0] cnt;

    logic [NREQ-1:0]  gnt_q;
    logic             done_q;
    logic             err_q;
    logic             load_q;
    logic             rd_q;
    logic [W-1:0]     result_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;

    logic [NREQ-1:0]  arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [W-1:0]     a_sel;
    logic [W-1:0]     b_sel;

    mod_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign a_sel = bus.a_in[arb_idx*W +: W];
    assign b_sel = bus.b_in[arb_idx*W +: W];

    // NOTE: reset is synchronous, so it lives inside the clocked block and
    // state updates use non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            win      <= '0;
            cnt      <= '0;
            gnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            load_q   <= 1'b0;
            rd_q     <= 1'b0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            done_q <= 1'b0;
            load_q <= 1'b0;
            rd_q   <= 1'b0;
            case (state)
                IDLE: begin
                    gnt_q <= '0;
                    err_q <= 1'b0;
                    if (arb_any) begin
                        gnt_q <= arb_grant;
                        win   <= arb_idx;
                        a_q   <= a_sel;
                        b_q   <= b_sel;
                        if (b_sel == '0) begin
                            err_q    <= 1'b1;
                            result_q <= '0;
                            done_q   <= 1'b1;
                            state    <= RESP;
                        end else begin
                            load_q <= 1'b1;
                            state  <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= SUB;
                end
                SUB: begin
                    if (bus.eng_lt) begin
                        rd_q  <= 1'b1;
                        state <= READ;
                    end else if (cnt == MAX_ITER) begin
                        err_q    <= 1'b1;
                        result_q <= '0;
                        done_q   <= 1'b1;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READ: begin
                    result_q <= bus.eng_result;
                    done_q   <= 1'b1;
                    state    <= RESP;
                end
                RESP: begin
                    gnt_q <= '0;
                    ptr   <= (win == LAST) ? '0 : win + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Subtract must act in the same cycle the engine reports remainder >= divisor.
    assign bus.eng_sub  = (state == SUB) && !bus.eng_lt && (cnt != MAX_ITER);

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.result   = result_q;
    assign bus.eng_load = load_q;
    assign bus.eng_rd   = rd_q;
    assign bus.eng_a    = a_q;
    assign bus.eng_b    = b_q;

endmodule
